// File: rtl/n_bit_serial_rx.sv
// Framed serial receiver: start(0), N data bits LSB-first, optional parity, stop(1).
// Define PARITY_CHECK_EN to add the parity bit and live parity_err checking.
module n_bit_serial_rx #(
  parameter int N       = 5,
  parameter int ODD_PAR = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sin,
  output logic [N-1:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         busy,
  output logic         frame_err,
  output logic         parity_err,
  output logic         overrun,
  input  logic         ovr_clr
);

  localparam int CW = $clog2(N + 1);

  if (N < 2 || ODD_PAR < 0 || ODD_PAR > 1) begin : g_cfg_check
    $error("n_bit_serial_rx: N must be >= 2 and ODD_PAR must be 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
`ifdef PARITY_CHECK_EN
    PARITY = 3'd2,
`endif
    STOP   = 3'd3,
    BREAK  = 3'd4
  } state_t;

`ifdef PARITY_CHECK_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  count;
  logic [N-1:0]   sr;
  logic           last_bit;
  logic           stop_good;
  logic           stop_bad;
  logic           deliver;
  logic           accept;
  logic           load;
  logic           par_bad;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A low stop bit parks the FSM in BREAK so a held-low line cannot look like a new start bit.
  always_comb begin
    state_nxt = state;
    last_bit  = (count == CW'(N - 1));
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      IDLE:   if (!sin) state_nxt = DATA;
      DATA:   if (last_bit) state_nxt = AFTER_DATA;
`ifdef PARITY_CHECK_EN
      PARITY: state_nxt = STOP;
`endif
      STOP: begin
        stop_good = sin;
        stop_bad  = !sin;
        state_nxt = sin ? IDLE : BREAK;
      end
      BREAK:  if (sin) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept  = dout_valid & dout_ready;
    deliver = stop_good & !par_bad;
    load    = deliver & (!dout_valid | accept);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      sr         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      if (state == IDLE) begin
        count <= '0;
      end else if (state == DATA) begin
        sr    <= {sin, sr[N-1:1]};
        count <= count + CW'(1);
      end
      if (load) begin
        dout       <= sr;
        dout_valid <= 1'b1;
      end else if (accept) begin
        dout_valid <= 1'b0;
      end
      // A dropped good frame sets overrun even if the consumer clears it in the same cycle.
      if (deliver && !load)
        overrun <= 1'b1;
      else if (ovr_clr)
        overrun <= 1'b0;
    end
  end

`ifdef PARITY_CHECK_EN
  logic par_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_bad   <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      if (state == PARITY)
        par_bad <= (sin != ((^sr) ^ (ODD_PAR != 0)));
      par_err_q <= stop_good & par_bad;
    end
  end

  assign parity_err = par_err_q;
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_n_bit_serial_rx.sv
// Directed bench for n_bit_serial_rx (N=5, even parity); covers parity frames when PARITY_CHECK_EN is defined.
module tb_n_bit_serial_rx;

  localparam int N = 5;

  logic         clk;
  logic         rst;
  logic         sin;
  logic [N-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         busy;
  logic         frame_err;
  logic         parity_err;
  logic         overrun;
  logic         ovr_clr;

  int checks;
  int failures;

  n_bit_serial_rx #(.N(N), .ODD_PAR(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .ovr_clr    (ovr_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one line bit, let one rising edge consume it, then settle 1ns past the edge.
  task automatic applyStimulus(input logic s);
    sin = s;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Parity bit is only placed on the line when the receiver expects one.
  task automatic sendFrame(input logic [N-1:0] d, input logic par, input logic stop_bit);
    applyStimulus(1'b0);
    for (int i = 0; i < N; i++) applyStimulus(d[i]);
`ifdef PARITY_CHECK_EN
    applyStimulus(par);
`else
    if (par === 1'bx) $display("[TB] unexpected parity argument");
`endif
    applyStimulus(stop_bit);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    sin        = 1'b1;
    dout_ready = 1'b0;
    ovr_clr    = 1'b0;

    $display("[TB] reset");
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    checkOutput("rst_busy",   8'(busy),       8'h0);
    checkOutput("rst_valid",  8'(dout_valid), 8'h0);
    checkOutput("rst_dout",   8'(dout),       8'h0);
    checkOutput("rst_ovr",    8'(overrun),    8'h0);
    checkOutput("rst_ferr",   8'(frame_err),  8'h0);
    rst = 1'b0;

    $display("[TB] idle line");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1);
    checkOutput("idle_busy",  8'(busy),       8'h0);
    checkOutput("idle_valid", 8'(dout_valid), 8'h0);
    checkOutput("idle_ferr",  8'(frame_err),  8'h0);
    checkOutput("idle_perr",  8'(parity_err), 8'h0);
    checkOutput("idle_ovr",   8'(overrun),    8'h0);

    $display("[TB] single frame 5'b01101");
    dout_ready = 1'b1;
    applyStimulus(1'b0);
    checkOutput("f1_busy_start", 8'(busy), 8'h1);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
`ifdef PARITY_CHECK_EN
    checkOutput("f1_valid_early", 8'(dout_valid), 8'h0);
    applyStimulus(1'b1);
`endif
    checkOutput("f1_valid_early", 8'(dout_valid), 8'h0);
    applyStimulus(1'b1);
    checkOutput("f1_valid", 8'(dout_valid), 8'h1);
    checkOutput("f1_dout",  8'(dout),       8'h0D);
    checkOutput("f1_busy",  8'(busy),       8'h0);
    applyStimulus(1'b1);
    checkOutput("f1_valid_drop", 8'(dout_valid), 8'h0);

    $display("[TB] back-to-back frames with consumer stalled");
    dout_ready = 1'b0;
    sendFrame(5'h1F, 1'b1, 1'b1);
    checkOutput("f2_valid", 8'(dout_valid), 8'h1);
    checkOutput("f2_dout",  8'(dout),       8'h1F);
    checkOutput("f2_ovr0",  8'(overrun),    8'h0);
    sendFrame(5'h0A, 1'b0, 1'b1);
    checkOutput("f3_dout",  8'(dout),       8'h1F);
    checkOutput("f3_valid", 8'(dout_valid), 8'h1);
    checkOutput("f3_ovr",   8'(overrun),    8'h1);
    ovr_clr = 1'b1;
    applyStimulus(1'b1);
    ovr_clr = 1'b0;
    checkOutput("clr_ovr",   8'(overrun),    8'h0);
    checkOutput("clr_dout",  8'(dout),       8'h1F);
    checkOutput("clr_valid", 8'(dout_valid), 8'h1);
    dout_ready = 1'b1;
    applyStimulus(1'b1);
    checkOutput("drain_valid", 8'(dout_valid), 8'h0);

    $display("[TB] framing error and break");
    sendFrame(5'h07, 1'b1, 1'b0);
    checkOutput("fe_pulse", 8'(frame_err),  8'h1);
    checkOutput("fe_valid", 8'(dout_valid), 8'h0);
    applyStimulus(1'b0);
    checkOutput("fe_pulse_end", 8'(frame_err), 8'h0);
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    checkOutput("brk_busy", 8'(busy), 8'h1);
    applyStimulus(1'b1);
    checkOutput("brk_exit_busy", 8'(busy),       8'h0);
    checkOutput("brk_valid",     8'(dout_valid), 8'h0);
    checkOutput("brk_ferr",      8'(frame_err),  8'h0);
    applyStimulus(1'b1);
    sendFrame(5'h03, 1'b0, 1'b1);
    checkOutput("f4_valid", 8'(dout_valid), 8'h1);
    checkOutput("f4_dout",  8'(dout),       8'h03);
    applyStimulus(1'b1);
    checkOutput("f4_drain", 8'(dout_valid), 8'h0);

`ifdef PARITY_CHECK_EN
    $display("[TB] parity frames");
    sendFrame(5'b00111, 1'b0, 1'b1);
    checkOutput("pe_pulse", 8'(parity_err), 8'h1);
    checkOutput("pe_valid", 8'(dout_valid), 8'h0);
    checkOutput("pe_ovr",   8'(overrun),    8'h0);
    applyStimulus(1'b1);
    checkOutput("pe_pulse_end", 8'(parity_err), 8'h0);
    sendFrame(5'b00111, 1'b1, 1'b1);
    checkOutput("pok_valid", 8'(dout_valid), 8'h1);
    checkOutput("pok_dout",  8'(dout),       8'h07);
    checkOutput("pok_perr",  8'(parity_err), 8'h0);
    applyStimulus(1'b1);
`endif

    $display("[TB] reset mid-frame");
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    rst = 1'b1;
    applyStimulus(1'b1);
    rst = 1'b0;
    checkOutput("mr_busy",  8'(busy),       8'h0);
    checkOutput("mr_ferr",  8'(frame_err),  8'h0);
    checkOutput("mr_perr",  8'(parity_err), 8'h0);
    checkOutput("mr_valid", 8'(dout_valid), 8'h0);
    checkOutput("mr_dout",  8'(dout),       8'h00);
    applyStimulus(1'b1);
    sendFrame(5'h15, 1'b1, 1'b1);
    checkOutput("f5_valid", 8'(dout_valid), 8'h1);
    checkOutput("f5_dout",  8'(dout),       8'h15);
    checkOutput("f5_ferr",  8'(frame_err),  8'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
